// File: rtl/alu_pkg.sv
// alu_pkg: opcode, compare-condition and FSM state encodings shared by the ALU.
package alu_pkg;
   localparam logic [3:0] OP_ADD  = 4'b0000;
   localparam logic [3:0] OP_SUB  = 4'b0001;
   localparam logic [3:0] OP_MUL  = 4'b0010;
   localparam logic [3:0] OP_CMP  = 4'b0100;
   localparam logic [3:0] OP_EPAR = 4'b0101;
   localparam logic [2:0] CND_EQ  = 3'd0;
   localparam logic [2:0] CND_NE  = 3'd1;
   localparam logic [2:0] CND_LT  = 3'd2;
   localparam logic [2:0] CND_LE  = 3'd3;
   localparam logic [2:0] CND_GT  = 3'd4;
   localparam logic [2:0] CND_GE  = 3'd5;
   typedef enum logic [1:0] {S_IDLE, S_EXEC, S_DONE} state_e;
endpackage

// File: rtl/alu_shift_mul.sv
// alu_shift_mul: iterative shift-add multiplier, one partial product per cycle.
module alu_shift_mul #(
   parameter int WIDTH = 16
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             done,
   output logic [WIDTH-1:0] p
);
   localparam int CW = $clog2(WIDTH + 1);
   logic [WIDTH-1:0] mcand_q, mplier_q, acc_q, acc_d;
   logic [CW-1:0]    cnt_q;
   always_comb begin
      acc_d = acc_q + (mplier_q[0] ? mcand_q : '0);
      done  = (cnt_q == CW'(1));
      p     = acc_d;
   end
   // done fires with the last step's sum so the caller captures it on that same edge
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         mcand_q  <= '0;
         mplier_q <= '0;
         acc_q    <= '0;
         cnt_q    <= '0;
      end else if (start) begin
         mcand_q  <= a;
         mplier_q <= b;
         acc_q    <= '0;
         cnt_q    <= CW'(WIDTH);
      end else if (cnt_q != '0) begin
         mcand_q  <= mcand_q << 1;
         mplier_q <= mplier_q >> 1;
         acc_q    <= acc_d;
         cnt_q    <= cnt_q - CW'(1);
      end
   end
endmodule

// File: rtl/alu_seq.sv
// alu_seq: handshaked ALU; single-cycle ADD/SUB/CMP/EPAR, iterative MUL, registered outputs.
module alu_seq
   import alu_pkg::*;
#(
   parameter int WIDTH      = 16,
   parameter bit SIGNED_CMP = 1'b0
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [3:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [2:0]       cond,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out,
   output logic             compres,
   output logic             carry,
   output logic             zero,
   output logic             illegal
);
   state_e           state_q, state_d;
   logic [WIDTH-1:0] out_q, out_d, mul_p;
   logic             compres_q, compres_d, carry_q, carry_d, zero_q, zero_d, illegal_q, illegal_d;
   logic [WIDTH:0]   sum, diff;
   logic             eq, lt, cres, mul_start, mul_done;
   alu_shift_mul #(.WIDTH(WIDTH)) u_mul (
      .clock(clock), .reset_n(reset_n), .start(mul_start),
      .a(a), .b(b), .done(mul_done), .p(mul_p)
   );
   always_comb begin
      sum  = {1'b0, a} + {1'b0, b};
      diff = {1'b0, a} - {1'b0, b};
      eq   = (a == b);
      lt   = SIGNED_CMP ? ($signed(a) < $signed(b)) : (a < b);
      cres = (cond == CND_EQ) ? eq :
             (cond == CND_NE) ? !eq :
             (cond == CND_LT) ? lt :
             (cond == CND_LE) ? (lt | eq) :
             (cond == CND_GT) ? !(lt | eq) : !lt;
   end
   always_comb begin
      state_d   = state_q;
      out_d     = out_q;
      compres_d = compres_q;
      carry_d   = carry_q;
      illegal_d = illegal_q;
      mul_start = 1'b0;
      case (state_q)
         S_IDLE: if (in_valid) begin
            state_d   = (op == OP_MUL) ? S_EXEC : S_DONE;
            mul_start = (op == OP_MUL);
            out_d     = '0;
            compres_d = 1'b0;
            carry_d   = 1'b0;
            illegal_d = 1'b0;
            case (op)
               OP_ADD:  {carry_d, out_d} = sum;
               OP_SUB:  {carry_d, out_d} = diff;
               OP_MUL:  ;
               OP_CMP:  begin
                  compres_d = (cond <= CND_GE) & cres;
                  illegal_d = (cond > CND_GE);
               end
               OP_EPAR: out_d = {{(WIDTH-1){1'b0}}, ^a};
               default: illegal_d = 1'b1;
            endcase
         end
         S_EXEC: if (mul_done) begin
            state_d = S_DONE;
            out_d   = mul_p;
         end
         default: if (out_ready) state_d = S_IDLE;
      endcase
      zero_d = (out_d == '0);
   end
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= S_IDLE;
         out_q     <= '0;
         compres_q <= 1'b0;
         carry_q   <= 1'b0;
         zero_q    <= 1'b0;
         illegal_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         out_q     <= out_d;
         compres_q <= compres_d;
         carry_q   <= carry_d;
         zero_q    <= zero_d;
         illegal_q <= illegal_d;
      end
   end
   assign in_ready  = (state_q == S_IDLE);
   assign out_valid = (state_q == S_DONE);
   assign out       = out_q;
   assign compres   = compres_q;
   assign carry     = carry_q;
   assign zero      = zero_q;
   assign illegal   = illegal_q;
endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed checks of alu_seq, unsigned and signed-compare instances side by side.
module tb_alu_seq;
   import alu_pkg::*;
   logic        clock = 1'b0, reset_n = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
   logic [3:0]  op = '0;
   logic [15:0] a = '0, b = '0;
   logic [2:0]  cond = '0;
   logic        in_ready, out_valid, compres, carry, zero, illegal;
   logic [15:0] out;
   logic        s_in_ready, s_out_valid, s_compres, s_carry, s_zero, s_illegal;
   logic [15:0] s_out;
   int          checks = 0, errors = 0;
   logic        bad;
   alu_seq #(.WIDTH(16), .SIGNED_CMP(1'b0)) dut (
      .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
      .op(op), .a(a), .b(b), .cond(cond), .out_valid(out_valid), .out_ready(out_ready),
      .out(out), .compres(compres), .carry(carry), .zero(zero), .illegal(illegal)
   );
   alu_seq #(.WIDTH(16), .SIGNED_CMP(1'b1)) dut_s (
      .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .in_ready(s_in_ready),
      .op(op), .a(a), .b(b), .cond(cond), .out_valid(s_out_valid), .out_ready(out_ready),
      .out(s_out), .compres(s_compres), .carry(s_carry), .zero(s_zero), .illegal(s_illegal)
   );
   always #5 clock = ~clock;
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask
   task automatic accept(input logic [3:0] o, input logic [15:0] x, input logic [15:0] y, input logic [2:0] c);
      @(negedge clock);
      op = o; a = x; b = y; cond = c; in_valid = 1'b1;
      @(posedge clock);
      #1;
      in_valid = 1'b0;
      a = 16'($urandom);
      b = 16'($urandom);
      op = OP_ADD;
      cond = 3'd1;
   endtask
   task automatic consume(input string tag);
      @(negedge clock);
      out_ready = 1'b1;
      in_valid = 1'b1;
      @(posedge clock);
      #1;
      out_ready = 1'b0;
      in_valid = 1'b0;
      chk({tag, "_idle_rdy"}, in_ready, 1);
      chk({tag, "_idle_ov"}, out_valid, 0);
   endtask
   initial begin
      #2;
      chk("rst_in_ready", in_ready, 1);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_flags", {out, compres, carry, zero, illegal}, 0);
      repeat (2) @(posedge clock);
      @(negedge clock);
      reset_n = 1'b1;
      accept(OP_ADD, 16'hFFFF, 16'h0001, 3'd0);
      chk("add_ov", out_valid, 1);
      chk("add_out", out, 16'h0000);
      chk("add_cz", {carry, zero, compres, illegal}, 4'b1100);
      consume("add");
      accept(OP_MUL, 16'h0012, 16'h0034, 3'd0);
      bad = out_valid | in_ready;
      for (int i = 2; i <= 16; i++) begin
         @(posedge clock);
         #1;
         if (out_valid || in_ready) bad = 1'b1;
      end
      chk("mul_busy", bad, 0);
      @(posedge clock);
      #1;
      chk("mul_ov17", out_valid, 1);
      chk("mul_out", out, 16'h03A8);
      chk("mul_cz", {carry, zero, compres, illegal}, 4'b0000);
      consume("mul");
      accept(OP_CMP, 16'hFFFF, 16'h0001, CND_LT);
      chk("cmp_lt_u", compres, 0);
      chk("cmp_lt_s", s_compres, 1);
      chk("cmp_out", {out, zero, illegal}, 18'b10);
      consume("cmp_lt");
      accept(OP_CMP, 16'h0005, 16'h0005, CND_LE);
      chk("cmp_le", {compres, s_compres}, 2'b11);
      consume("cmp_le");
      accept(OP_CMP, 16'h8000, 16'h0001, CND_GT);
      chk("cmp_gt", {compres, s_compres}, 2'b10);
      consume("cmp_gt");
      accept(OP_SUB, 16'h0003, 16'h0005, 3'd0);
      chk("sub_out", out, 16'hFFFE);
      chk("sub_carry", carry, 1);
      bad = 1'b0;
      repeat (5) begin
         @(posedge clock);
         #1;
         if (out !== 16'hFFFE || carry !== 1'b1 || out_valid !== 1'b1 || zero !== 1'b0) bad = 1'b1;
      end
      chk("sub_hold", bad, 0);
      consume("sub");
      accept(4'hF, 16'h1234, 16'h0001, 3'd0);
      chk("ill_op", {out, illegal, compres, carry, zero}, 20'b1001);
      consume("ill_op");
      accept(OP_CMP, 16'h0005, 16'h0005, 3'd7);
      chk("ill_cond", {out, illegal, compres, carry, zero}, 20'b1001);
      consume("ill_cond");
      accept(OP_EPAR, 16'h0107, 16'h0000, 3'd0);
      chk("epar_even", {out, zero, illegal}, 18'b10);
      consume("epar_even");
      accept(OP_EPAR, 16'h0007, 16'h0000, 3'd0);
      chk("epar_odd", {out, zero, illegal}, 18'b100);
      consume("epar_odd");
      accept(OP_MUL, 16'h0012, 16'h0034, 3'd0);
      repeat (7) @(posedge clock);
      #1;
      reset_n = 1'b0;
      #1;
      chk("abort_rdy", in_ready, 1);
      chk("abort_ov", out_valid, 0);
      @(negedge clock);
      reset_n = 1'b1;
      bad = 1'b0;
      repeat (20) begin
         @(posedge clock);
         #1;
         if (out_valid) bad = 1'b1;
      end
      chk("abort_noresult", bad, 0);
      accept(OP_ADD, 16'h0002, 16'h0003, 3'd0);
      chk("post_add_ov", out_valid, 1);
      chk("post_add", {out, carry, zero, illegal}, {16'h0005, 3'b000});
      consume("post");
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/alu_seq.md
ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 Parameter WIDTH, default 16: operand and result width in bits; the block SHALL support any WIDTH >= 2.
REQ-002 Parameter SIGNED_CMP, default 0: 0 selects unsigned compare, 1 selects two's-complement compare.
REQ-003 Port clock, input, 1: the single clock; all state SHALL update on its rising edge.
REQ-004 Port reset_n, input, 1: reset, asynchronous assert, active-low.
REQ-005 Port in_valid, input, 1: a request is present on op/a/b/cond.
REQ-006 Port in_ready, output, 1: the block can accept a request.
REQ-007 Port op, input, 4: opcode; 0000 ADD, 0001 SUB, 0010 MUL, 0100 CMP, 0101 EPAR; all other codes are illegal.
REQ-008 Port a, input, WIDTH: first operand.
REQ-009 Port b, input, WIDTH: second operand.
REQ-010 Port cond, input, 3: CMP condition; 0 EQ, 1 NE, 2 LT, 3 LE, 4 GT, 5 GE (a relative to b); 6 and 7 are illegal.
REQ-011 Port out_valid, output, 1: the result is valid.
REQ-012 Port out_ready, input, 1: the consumer accepts the result.
REQ-013 Port out, output, WIDTH: the result.
REQ-014 Port compres, output, 1: compare result.
REQ-015 Port carry, output, 1: ADD carry-out, or SUB borrow.
REQ-016 Port zero, output, 1: high when out == 0.
REQ-017 Port illegal, output, 1: an illegal op or cond was accepted.

Function
REQ-018 The FSM SHALL have three states: IDLE, EXEC and DONE; in_ready SHALL be 1 only in IDLE, and out_valid SHALL be 1 only in DONE.
REQ-019 An accept occurs when in_valid and in_ready are both 1 at a clock edge; op, a, b and cond SHALL be latched on that edge, and changes to the inputs afterwards SHALL have no effect on the result.
REQ-020 ADD, SUB, CMP, EPAR and illegal ops SHALL go from IDLE to DONE on the accept edge, so that out_valid is high after exactly 1 edge.
REQ-021 MUL SHALL go from IDLE to EXEC and perform one shift-add step per cycle for WIDTH cycles, then go to DONE, so that out_valid is high exactly WIDTH+1 edges after the accept.
REQ-022 In DONE, out, compres, carry, zero and illegal SHALL hold stable while out_ready is 0; when out_ready is 1 the block SHALL return to IDLE, and no new accept SHALL occur in that same cycle.
REQ-023 ADD and SUB SHALL be computed modulo 2^WIDTH; carry SHALL be the bit-WIDTH carry for ADD, and for SUB it SHALL be 1 exactly when a < b unsigned.
REQ-024 MUL SHALL produce the low WIDTH bits of the unsigned product a*b, with carry 0.
REQ-025 EPAR SHALL set out[0] to the XOR of all WIDTH bits of a, and all other out bits to 0.
REQ-026 CMP SHALL set out = 0 and compres to the result of the selected condition, using signed or unsigned compare according to SIGNED_CMP.
REQ-027 For every op other than CMP, compres SHALL be 0; for every op other than ADD, SUB and MUL, carry SHALL be 0.
REQ-028 An illegal op, or CMP with cond 6 or 7, SHALL produce out = 0, compres = 0, carry = 0 and illegal = 1.
REQ-029 zero SHALL be recomputed from the final out for every op, including CMP, EPAR and illegal ops.
REQ-030 Outputs SHALL come directly from registers, with no combinational path from any input to any output.

Reset
REQ-031 While reset_n is 0, the state SHALL be IDLE, in_ready SHALL be 1, and out_valid, out, compres, carry, zero and illegal SHALL all be 0.
REQ-032 A reset asserted in EXEC or DONE SHALL abort the operation with no result delivered; the first accept after reset_n rises SHALL behave as if from power-up.

Structure
REQ-033 A shared package alu_pkg SHALL hold the opcode constants, the cond constants and the FSM state encoding.
REQ-034 The iterative multiplier SHALL be a sub-module alu_shift_mul, with start and done signals and WIDTH as a parameter; all other ops SHALL be implemented inline.

Verification (WIDTH=16 unless stated)
REQ-035 ADD a=0xFFFF, b=0x0001 -> out 0x0000, carry 1, zero 1, out_valid exactly 1 edge after the accept.
REQ-036 MUL a=0x0012, b=0x0034 -> out 0x03A8, out_valid exactly 17 edges after the accept; in_ready 0 throughout.
REQ-037 CMP a=0xFFFF, b=0x0001, cond LT -> compres 0 with SIGNED_CMP=0, and compres 1 with SIGNED_CMP=1.
REQ-038 SUB a=0x0003, b=0x0005 with out_ready held 0 for 5 cycles -> out 0xFFFE and carry 1, stable across all 5 cycles; IDLE one edge after out_ready rises.
REQ-039 op 0xF, or CMP with cond 7 -> out 0, illegal 1, compres 0; EPAR a=0x0107 -> out 0x0000, zero 1.
REQ-040 reset_n pulsed low at cycle 8 of a MUL -> no out_valid; in_ready 1 immediately; the next ADD 2+3 returns 0x0005.
